// File: rtl/card_pkg.sv
// Shared constants, FSM state type and per-card scoring helper for the card dealer.
package card_pkg;
   localparam logic [5:0] CARD_EMPTY = 6'h3F;
   localparam int         DECK_SIZE  = 52;
   localparam int         NUM_SLOTS  = 9;

   typedef enum logic [2:0] {IDLE, DRAW, PROBE, ASSIGN, SCORE} dealer_state_t;

   // Aces count 1 here; the soft +10 is decided on the whole hand, not per card
   function automatic logic [3:0] card_value(input logic [5:0] code);
      logic [3:0] rank;
      rank = 4'(code >> 2);
      if (rank == 4'd0)
         return 4'd1;
      else if (rank <= 4'd9)
         return rank + 4'd1;
      else
         return 4'd10;
   endfunction
endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) that loads SEED on reset.
module lfsr16 #(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] o_state
);
   logic [15:0] r_state;
   logic        w_feedback;

   // Right-shifting form: tap 16 sits at bit 0, taps 14/13/11 at bits 2/3/5
   assign w_feedback = r_state[0] ^ r_state[2] ^ r_state[3] ^ r_state[5];

   always_ff @(posedge clk) begin
      if (rst)
         r_state <= SEED;
      else
         r_state <= {w_feedback, r_state[15:1]};
   end

   assign o_state = r_state;
endmodule

// File: rtl/card_dealer.sv
// Deals cards without replacement into the hand slots and keeps the blackjack score.
// Optional CARD_DEALER_SEQ_DECK_EN: draw from a sequential pointer instead of the LFSR.
module card_dealer #(
   parameter int          NUM_SLOTS = 9,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       deal_req,
   input  logic       new_round,
   output logic [5:0] card_code [0:NUM_SLOTS-1],
   output logic [3:0] card_count,
   output logic [6:0] hand_value,
   output logic       busted,
   output logic       blackjack,
   output logic       ready,
   output logic       deal_ack
);
   import card_pkg::*;

   localparam logic [3:0] SLOT_LIMIT = 4'(NUM_SLOTS);
   localparam logic [5:0] DECK_CODES = 6'(DECK_SIZE);
   localparam logic [5:0] LAST_CARD  = 6'(DECK_SIZE - 1);

   dealer_state_t        r_state;
   dealer_state_t        w_nextState;
   logic [DECK_SIZE-1:0] r_used;
   logic [5:0]           r_cand;
   logic [5:0]           r_codes [0:NUM_SLOTS-1];
   logic [3:0]           r_count;
   logic [6:0]           r_hard;
   logic                 r_hasAce;
   logic [6:0]           r_handValue;
   logic                 r_busted;
   logic                 r_blackjack;
   logic                 r_ready;
   logic                 r_ack;

   logic [15:0]          w_lfsr;
   logic                 w_unusedLfsr;
   logic [5:0]           w_rawCand;
   logic [5:0]           w_drawCand;
   logic [5:0]           w_probeNext;
   logic                 w_candUsed;
   logic [6:0]           w_newHard;
   logic                 w_newAce;
   logic [6:0]           w_newScore;
   logic [3:0]           w_nextCount;
   logic                 w_nextReady;

   lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
      .clk     (clk),
      .rst     (rst),
      .o_state (w_lfsr)
   );

`ifdef CARD_DEALER_SEQ_DECK_EN
   logic [5:0] r_seqPtr;

   // Only reset clears the pointer so successive rounds keep walking the deck
   always_ff @(posedge clk) begin
      if (rst)
         r_seqPtr <= 6'd0;
      else if (r_state == ASSIGN && !new_round)
         r_seqPtr <= (r_seqPtr == LAST_CARD) ? 6'd0 : r_seqPtr + 6'd1;
   end

   assign w_rawCand    = r_seqPtr;
   assign w_unusedLfsr = ^w_lfsr;
`else
   assign w_rawCand    = w_lfsr[5:0];
   assign w_unusedLfsr = ^w_lfsr[15:6];
`endif

   always_ff @(posedge clk) begin
      if (rst)
         r_state <= IDLE;
      else
         r_state <= w_nextState;
   end

   // new_round aborts any deal in flight and drops a same-cycle deal_req
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (deal_req && r_ready) w_nextState = DRAW;
         DRAW:    w_nextState = PROBE;
         PROBE:   if (!w_candUsed) w_nextState = ASSIGN;
         ASSIGN:  w_nextState = SCORE;
         SCORE:   w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
      if (new_round)
         w_nextState = IDLE;
   end

   // Score is computed from the landing card so codes, count and score publish on one edge
   always_comb begin
      w_drawCand  = (w_rawCand >= DECK_CODES) ? w_rawCand - DECK_CODES : w_rawCand;
      w_candUsed  = r_used[r_cand];
      w_probeNext = (r_cand == LAST_CARD) ? 6'd0 : r_cand + 6'd1;
      w_newHard   = r_hard + 7'(card_value(r_cand));
      w_newAce    = r_hasAce | (r_cand[5:2] == 4'd0);
      w_newScore  = (w_newAce && w_newHard <= 7'd11) ? w_newHard + 7'd10 : w_newHard;
      w_nextCount = new_round ? 4'd0 : ((r_state == ASSIGN) ? r_count + 4'd1 : r_count);
      w_nextReady = (w_nextState == IDLE) && (w_nextCount < SLOT_LIMIT);
   end

   always_ff @(posedge clk) begin
      if (rst || new_round) begin
         r_used      <= '0;
         r_cand      <= 6'd0;
         r_count     <= 4'd0;
         r_hard      <= 7'd0;
         r_hasAce    <= 1'b0;
         r_handValue <= 7'd0;
         r_busted    <= 1'b0;
         r_blackjack <= 1'b0;
         r_ack       <= 1'b0;
         r_ready     <= 1'b1;
         for (int i = 0; i < NUM_SLOTS; i++)
            r_codes[i] <= CARD_EMPTY;
      end else begin
         r_ack   <= 1'b0;
         r_ready <= w_nextReady;
         case (r_state)
            DRAW:  r_cand <= w_drawCand;
            PROBE: if (w_candUsed) r_cand <= w_probeNext;
            ASSIGN: begin
               r_codes[r_count] <= r_cand;
               r_used[r_cand]   <= 1'b1;
               r_count          <= r_count + 4'd1;
               r_hard           <= w_newHard;
               r_hasAce         <= w_newAce;
               r_handValue      <= w_newScore;
               r_busted         <= (w_newScore > 7'd21);
               r_blackjack      <= (r_count == 4'd1) && (w_newScore == 7'd21);
               r_ack            <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign card_code  = r_codes;
   assign card_count = r_count;
   assign hand_value = r_handValue;
   assign busted     = r_busted;
   assign blackjack  = r_blackjack;
   assign ready      = r_ready;
   assign deal_ack   = r_ack;
endmodule

// File: tb/tb_card_dealer.sv
// Self-checking bench for card_dealer: a scripted cycle table plus model-predicted deals.
// Works in both the LFSR build and the CARD_DEALER_SEQ_DECK_EN build.
module tb_card_dealer;
   localparam logic [15:0] SEED      = 16'hACE1;
   localparam int          ANY       = 0;
   localparam int          COLLIDE   = 1;
   localparam int          BLACKJACK = 2;
   localparam int          ACE       = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       deal_req;
   logic       new_round;
   logic [5:0] card_code [0:8];
   logic [3:0] card_count;
   logic [6:0] hand_value;
   logic       busted;
   logic       blackjack;
   logic       ready;
   logic       deal_ack;

   int compared   = 0;
   int mismatched = 0;

   // Reference model state, expressed in deck/hand terms
   logic [15:0] mLfsr;
   bit          mUsed [52];
   int          mCodes [9];
   int          mCount;
   int          mPtr;

   typedef struct {
      bit req;
      bit nr;
      bit ack;
      bit rdy;
      int cnt;
   } vec_t;

   vec_t tbl [14];

   card_dealer #(.NUM_SLOTS(9), .LFSR_SEED(SEED)) dut (
      .clk        (clk),
      .rst        (rst),
      .deal_req   (deal_req),
      .new_round  (new_round),
      .card_code  (card_code),
      .card_count (card_count),
      .hand_value (hand_value),
      .busted     (busted),
      .blackjack  (blackjack),
      .ready      (ready),
      .deal_ack   (deal_ack)
   );

   always #5 clk = ~clk;

   // The generator polynomial as shift/xor arithmetic on the whole word
   function automatic logic [15:0] lfsrStep(input logic [15:0] s);
      logic [15:0] fb;
      fb = ((s >> 0) ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 16'h0001;
      return (s >> 1) | (fb << 15);
   endfunction

   always @(posedge clk) mLfsr <= rst ? SEED : lfsrStep(mLfsr);

   function automatic int valueOf(input int code);
      int rank;
      rank = code / 4;
      if (rank == 0) return 1;
      if (rank <= 9) return rank + 1;
      return 10;
   endfunction

   // Best score of the current model hand with one extra card added
   function automatic int scoreWith(input int extra);
      int hard;
      bit ace;
      hard = valueOf(extra);
      ace  = (extra / 4 == 0);
      for (int i = 0; i < mCount; i++) begin
         hard += valueOf(mCodes[i]);
         if (mCodes[i] / 4 == 0) ace = 1;
      end
      return (ace && hard <= 11) ? hard + 10 : hard;
   endfunction

   // Card that lands given the LFSR value seen in the DRAW cycle, and collisions skipped
   function automatic void predict(input logic [15:0] lf, output int code, output int k);
      int c;
`ifdef CARD_DEALER_SEQ_DECK_EN
      c = mPtr;
`else
      c = int'(lf) % 64;
      if (c >= 52) c -= 52;
`endif
      k = 0;
      while (mUsed[c] && k < 52) begin
         c = (c + 1) % 52;
         k++;
      end
      code = c;
   endfunction

   function automatic bit wanted(input int mode, input int code, input int k);
      case (mode)
         COLLIDE:   return k > 0;
         BLACKJACK: return (mCount == 1) && (scoreWith(code) == 21);
         ACE:       return code / 4 == 0;
         default:   return 1'b1;
      endcase
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic clearModel();
      mCount = 0;
      for (int i = 0; i < 52; i++) mUsed[i] = 0;
      for (int i = 0; i < 9; i++) mCodes[i] = 63;
   endtask

   task automatic doReset();
      rst       = 1'b1;
      deal_req  = 1'b0;
      new_round = 1'b0;
      repeat (3) @(negedge clk);
      rst  = 1'b0;
      mPtr = 0;
      clearModel();
   endtask

   // Every slot must match the model; filled ones must be legal and distinct
   task automatic checkHand(input string tag);
      bit ok;
      ok = 1;
      for (int i = 0; i < 9; i++) begin
         if (i < mCount) begin
            if (int'(card_code[i]) >= 52) ok = 0;
            if (int'(card_code[i]) != mCodes[i]) ok = 0;
            for (int j = 0; j < i; j++)
               if (card_code[j] == card_code[i]) ok = 0;
         end else if (card_code[i] !== 6'h3F) begin
            ok = 0;
         end
      end
      checkOutput({tag, " hand codes ok"}, int'(ok), 1);
   endtask

   task automatic applyStimulus(input int idx);
      deal_req  = tbl[idx].req;
      new_round = tbl[idx].nr;
      @(negedge clk);
      checkOutput($sformatf("vec%0d deal_ack", idx), int'(deal_ack), int'(tbl[idx].ack));
      checkOutput($sformatf("vec%0d ready", idx), int'(ready), int'(tbl[idx].rdy));
      checkOutput($sformatf("vec%0d card_count", idx), int'(card_count), tbl[idx].cnt);
   endtask

   // Picks a request time whose predicted outcome suits 'mode', deals, and checks the landing
   task automatic dealCard(input int mode, input bit hold);
      logic [15:0] lf;
      int d, code, k, n, expScore;
      bit stable;
      lf = mLfsr;
      d  = 0;
      if (!hold) begin
         for (int t = 0; t < 1500; t++) begin
            lf = lfsrStep(lf);
            predict(lf, code, k);
            if (wanted(mode, code, k)) begin
               d = t;
               break;
            end
         end
      end
      repeat (d) @(negedge clk);
      checkOutput($sformatf("deal%0d ready before", mCount), int'(ready), 1);
      predict(lfsrStep(mLfsr), code, k);
      expScore = scoreWith(code);
      deal_req = 1'b1;
      @(negedge clk);
      if (!hold) deal_req = 1'b0;
      checkOutput($sformatf("deal%0d ready after accept", mCount), int'(ready), 0);
      n      = 0;
      stable = 1;
      while (n < 80 && deal_ack !== 1'b1) begin
         @(negedge clk);
         n++;
         if (deal_ack !== 1'b1 && (int'(card_count) != mCount || card_code[mCount] !== 6'h3F))
            stable = 0;
      end
      // Ack sits in the 4th cycle after acceptance, i.e. 3 edges later, plus one per collision
      checkOutput($sformatf("deal%0d ack latency", mCount), n, 3 + k);
      checkOutput($sformatf("deal%0d stable before ack", mCount), int'(stable), 1);
      checkOutput($sformatf("deal%0d code", mCount), int'(card_code[mCount]), code);
      checkOutput($sformatf("deal%0d card_count", mCount), int'(card_count), mCount + 1);
      checkOutput($sformatf("deal%0d hand_value", mCount), int'(hand_value), expScore);
      checkOutput($sformatf("deal%0d busted", mCount), int'(busted), int'(expScore > 21));
      checkOutput($sformatf("deal%0d blackjack", mCount), int'(blackjack),
                  int'(mCount == 1 && expScore == 21));
      mUsed[code]    = 1;
      mCodes[mCount] = code;
      mCount++;
`ifdef CARD_DEALER_SEQ_DECK_EN
      mPtr = (mPtr + 1) % 52;
`endif
      @(negedge clk);
      checkOutput($sformatf("deal%0d ack single pulse", mCount - 1), int'(deal_ack), 0);
      checkOutput($sformatf("deal%0d ready back", mCount - 1), int'(ready), int'(mCount < 9));
   endtask

   task automatic checkFullIgnored(input string tag);
      int acks;
      acks     = 0;
      deal_req = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (deal_ack === 1'b1) acks++;
      end
      deal_req = 1'b0;
      checkOutput({tag, " full: no ack"}, acks, 0);
      checkOutput({tag, " full: card_count"}, int'(card_count), 9);
      checkOutput({tag, " full: ready"}, int'(ready), 0);
      checkHand({tag, " full"});
   endtask

   task automatic startRound(input string tag);
      new_round = 1'b1;
      @(negedge clk);
      new_round = 1'b0;
      clearModel();
      checkOutput({tag, " new_round card_count"}, int'(card_count), 0);
      checkOutput({tag, " new_round ready"}, int'(ready), 1);
      checkOutput({tag, " new_round hand_value"}, int'(hand_value), 0);
      checkOutput({tag, " new_round busted"}, int'(busted), 0);
      checkHand({tag, " new_round"});
   endtask

   initial begin
      #900000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int acks;
      clearModel();
      doReset();

      checkOutput("reset card_count", int'(card_count), 0);
      checkOutput("reset hand_value", int'(hand_value), 0);
      checkOutput("reset busted", int'(busted), 0);
      checkOutput("reset blackjack", int'(blackjack), 0);
      checkOutput("reset deal_ack", int'(deal_ack), 0);
      checkOutput("reset ready", int'(ready), 1);
      checkHand("reset");

      // One full deal, ignored busy request, then a deal aborted by new_round two edges in,
      // then new_round together with deal_req (request dropped)
      tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0};
      tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 0};
      tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0};
      tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1};
      tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1};
      tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1};
      tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1};
      tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 0};
      tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 0};
      tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 0};
      tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 0};
      tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 0};
      tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 0};
      tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 0};
      for (int i = 0; i < 14; i++) applyStimulus(i);
      deal_req  = 1'b0;
      new_round = 1'b0;
      checkOutput("table end hand_value", int'(hand_value), 0);
      checkHand("table end");

      // Round A from a fresh reset: ace, try for blackjack, then collision-seeking deals
      doReset();
      dealCard(ACE, 1'b0);
      dealCard(BLACKJACK, 1'b0);
      for (int i = 0; i < 7; i++) dealCard((i % 2 == 0) ? COLLIDE : ANY, 1'b0);
      checkHand("roundA");
      checkFullIgnored("roundA");

      // Round B: deal_req held high throughout, one ack per idle acceptance
      startRound("roundB");
      for (int i = 0; i < 9; i++) dealCard(ANY, 1'b1);
      checkHand("roundB");
      checkFullIgnored("roundB");

      // Round C: random idle gaps and random collision seeking
      startRound("roundC");
      for (int i = 0; i < 5; i++) begin
         repeat ($urandom_range(0, 5)) @(negedge clk);
         dealCard(($urandom_range(0, 1) == 1) ? COLLIDE : ANY, 1'b0);
      end
      checkHand("roundC");

      // Mid-deal abort on a non-empty hand: new_round two edges after acceptance
      deal_req = 1'b1;
      @(negedge clk);
      deal_req = 1'b0;
      @(negedge clk);
      new_round = 1'b1;
      @(negedge clk);
      new_round = 1'b0;
      clearModel();
      acks = 0;
      repeat (6) begin
         @(negedge clk);
         if (deal_ack === 1'b1) acks++;
      end
      checkOutput("abort no ack", acks, 0);
      checkOutput("abort card_count", int'(card_count), 0);
      checkOutput("abort ready", int'(ready), 1);
      checkOutput("abort hand_value", int'(hand_value), 0);
      checkHand("abort");
      dealCard(ANY, 1'b0);
      checkHand("after abort");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
